ifetch_queue: RTL

//  Instruction prefetch stage upstream of instr_dec. Fetches sequential 16-bit words

---
 rtl/ifetch_queue_pkg.sv | 21 ++
 rtl/ifetch_queue_fifo.sv | 62 ++++++
 rtl/ifetch_queue.sv | 91 +++++++++
 3 files changed

// File: rtl/ifetch_queue_pkg.sv
// Shared constants for the instruction prefetch queue.
package ifetch_queue_pkg;

  // Address / instruction word width.
  localparam int unsigned IQ_AW = 16;

  // Default queue depth; also bounds occupancy plus in-flight fetches.
  localparam int unsigned IQ_DEPTH = 4;

  // Width of the occupancy output (0..DEPTH).
  localparam int unsigned IQ_LVL_W = 3;

  // Fetch addresses are word aligned.
  localparam logic [15:0] IQ_ALIGN_MASK = 16'hFFFE;

  // Force an address onto a word boundary.
  function automatic logic [15:0] iq_align(input logic [15:0] addr);
    return addr & IQ_ALIGN_MASK;
  endfunction

endpackage

// File: rtl/ifetch_queue_fifo.sv
// Synchronous FIFO of {addr, word} entries with flush, count and full/empty flags.
module ifetch_queue_fifo
  import ifetch_queue_pkg::*;
#(
  parameter int unsigned DEPTH = IQ_DEPTH,
  parameter int unsigned WIDTH = 2 * IQ_AW
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic                     i_flush,
  input  logic [WIDTH-1:0]         i_wdata,
  output logic [WIDTH-1:0]         o_rdata,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_full,
  output logic                     o_empty
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;

  logic w_do_push;
  logic w_do_pop;

  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_rdata = r_mem[r_rd_ptr];

  // A pop frees the slot in the same cycle, so push-while-full is legal alongside a pop.
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);

  // Pointer and occupancy bookkeeping; flush empties the queue like a reset.
  always_ff @(posedge clk) begin
    if (rst || i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      r_count <= r_count + CW'(w_do_push) - CW'(w_do_pop);
    end
  end

  // Entry storage; needs no reset since empty entries are never presented as valid.
  always_ff @(posedge clk) begin
    if (w_do_push && !rst && !i_flush) r_mem[r_wr_ptr] <= i_wdata;
  end

  // The credit rule upstream must never let a push land on a full queue.
  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(i_push && o_full && !i_pop && !i_flush));

endmodule

// File: rtl/ifetch_queue.sv
// Instruction prefetch stage: fetches sequential words over a req/gnt port into a small
// queue and hands them to the decoder with valid/pop; flushes and restarts on redirect.
module ifetch_queue
  import ifetch_queue_pkg::*;
#(
  parameter int unsigned DEPTH = IQ_DEPTH,
  parameter int unsigned AW    = IQ_AW
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [AW-1:0]       RST_VEC,
  output logic                IF_req,
  output logic [AW-1:0]       IF_addr,
  input  logic                IF_gnt,
  input  logic [AW-1:0]       IF_rdata,
  output logic [AW-1:0]       IW_out,
  output logic [AW-1:0]       IW_addr,
  output logic                IW_valid,
  input  logic                IW_pop,
  input  logic                REDIR,
  input  logic [AW-1:0]       REDIR_addr,
  output logic [IQ_LVL_W-1:0] IF_level
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic [AW-1:0] r_fa;          // next fetch address
  logic          r_inflight;    // a request was accepted last cycle; its data returns now
  logic [AW-1:0] r_infl_addr;   // address of the in-flight request

  logic [CW-1:0]     w_count;
  logic              w_full;
  logic              w_empty;
  logic              w_credit_ok;
  logic              w_accept;
  logic              w_push;
  logic              w_pop;
  logic [2*AW-1:0]   w_head;

  // Credit: queued words plus the outstanding fetch must leave room for one more.
  assign w_credit_ok = ((32'(w_count) + 32'(r_inflight)) < DEPTH) && !w_full;

  assign IF_req   = !rst && !REDIR && w_credit_ok;
  assign IF_addr  = r_fa;
  assign w_accept = IF_req && IF_gnt;

  // Returning data is written at the end of its data cycle unless a redirect kills it.
  assign w_push = r_inflight && !REDIR && !rst;
  assign w_pop  = IW_valid && IW_pop && !REDIR;

  assign IW_valid = !w_empty;
  assign IW_addr  = w_head[2*AW-1:AW];
  assign IW_out   = w_head[AW-1:0];
  assign IF_level = IQ_LVL_W'(w_count);

  // Fetch pointer and in-flight tracking; clearing r_inflight on redirect/reset acts as the
  // kill flag so stale data never reaches the queue.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_fa        <= iq_align(RST_VEC);
      r_inflight  <= 1'b0;
      r_infl_addr <= '0;
    end else if (REDIR) begin
      r_fa        <= iq_align(REDIR_addr);
      r_inflight  <= 1'b0;
    end else begin
      r_inflight <= w_accept;
      if (w_accept) begin
        r_infl_addr <= r_fa;
        r_fa        <= r_fa + AW'(2);
      end
    end
  end

  ifetch_queue_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (2 * AW)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (REDIR),
    .i_wdata ({r_infl_addr, IF_rdata}),
    .o_rdata (w_head),
    .o_count (w_count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

endmodule
